// File: rtl/apb_master_bridge_pkg.sv
// rtl/apb_master_bridge_pkg.sv - shared APB encodings, widths and transfer structs
package apb_master_bridge_pkg;

  localparam int ADDRESS_WIDTH  = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int NO_OF_SLAVES   = 16;
  localparam int TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE_STATE   = 2'd0,
    SETUP_STATE  = 2'd1,
    ACCESS_STATE = 2'd2
  } operation_states_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  // Monitor-side view of one completed transfer
  typedef struct packed {
    tx_type_e                tx_type;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
    logic                     slverr;
  } apb_transfer_char_s;

  // Sized at the maximum widths so narrower bridges zero-extend into it
  typedef struct packed {
    tx_type_e                   write;
    logic [ADDRESS_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [DATA_WIDTH/8-1:0]    strb;
    logic [2:0]                 prot;
  } apb_cmd_s;

endpackage

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command/response and APB bus bundle for the bridge
interface apb_master_bridge_if #(
  parameter int ADDRESS_WIDTH = apb_master_bridge_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = apb_master_bridge_pkg::DATA_WIDTH,
  parameter int NO_OF_SLAVES  = apb_master_bridge_pkg::NO_OF_SLAVES
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDRESS_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_strb;
  logic [2:0]                cmd_prot;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_slverr;
  logic                      rsp_timeout;

  logic [ADDRESS_WIDTH-1:0]  paddr;
  logic                      pwrite;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic [NO_OF_SLAVES-1:0]   pselx;
  logic                      penable;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output paddr, pwrite, pwdata, pstrb, pprot, pselx, penable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  paddr, pwrite, pwdata, pstrb, pprot, pselx, penable
  );

endinterface

// File: rtl/apb_master_bridge_slave_decoder.sv
// rtl/apb_master_bridge_slave_decoder.sv - upper address bits to one-hot pselx
module apb_slave_decoder #(
  parameter int NO_OF_SLAVES = apb_master_bridge_pkg::NO_OF_SLAVES
) (
  input  logic [$clog2(NO_OF_SLAVES)-1:0] slave_idx,
  input  logic                            sel_en,
  output logic [NO_OF_SLAVES-1:0]         pselx
);

  always_comb begin
    pselx = '0;
    if (sel_en) pselx[slave_idx] = 1'b1;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB requester with valid/ready cmd/rsp
// Optional ACCESS wait limit enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDRESS_WIDTH  = apb_master_bridge_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = apb_master_bridge_pkg::DATA_WIDTH,
  parameter int NO_OF_SLAVES   = apb_master_bridge_pkg::NO_OF_SLAVES,
  parameter int TIMEOUT_CYCLES = apb_master_bridge_pkg::TIMEOUT_CYCLES
) (
  input logic                 pclk,
  input logic                 preset,
  apb_master_bridge_if.master bus
);
  import apb_master_bridge_pkg::*;

  localparam int SEL_W  = $clog2(NO_OF_SLAVES);
  localparam int STRB_W = DATA_WIDTH / 8;

  operation_states_e     state_q, state_d;
  apb_cmd_s              cmd_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_slverr_q;
  logic                  rsp_timeout_q;
  logic                  accept, complete, timed_out, sel_en, penable_c;

  assign bus.cmd_ready = !preset && (state_q == IDLE_STATE) && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;

  // Counts completed pready-low ACCESS cycles; the limit-th one ends the transfer
  always_ff @(posedge pclk) begin
    if (preset || state_q == SETUP_STATE) wait_cnt <= '0;
    else if (state_q == ACCESS_STATE && !bus.pready) wait_cnt <= wait_cnt + TO_W'(1);
  end

  assign timed_out = (state_q == ACCESS_STATE) && !bus.pready &&
                     (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_en    = 1'b0;
    penable_c = 1'b0;
    complete  = 1'b0;
    case (state_q)
      IDLE_STATE:   if (accept) state_d = SETUP_STATE;
      SETUP_STATE: begin
        sel_en  = 1'b1;
        state_d = ACCESS_STATE;
      end
      ACCESS_STATE: begin
        sel_en    = 1'b1;
        penable_c = 1'b1;
        if (bus.pready || timed_out) begin
          complete = 1'b1;
          state_d  = IDLE_STATE;
        end
      end
      default:      state_d = IDLE_STATE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE_STATE;
      cmd_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q.write <= tx_type_e'(bus.cmd_write);
        cmd_q.addr  <= 32'(bus.cmd_addr);
        cmd_q.wdata <= bus.cmd_write ? 32'(bus.cmd_wdata) : '0;
        cmd_q.strb  <= bus.cmd_write ? 4'(bus.cmd_strb) : '0;
        cmd_q.prot  <= bus.cmd_prot;
      end
      // A response can only complete after the previous one drained at accept
      if (complete) begin
        rsp_valid_q   <= 1'b1;
        rsp_rdata_q   <= (cmd_q.write == READ && !timed_out) ? bus.prdata : '0;
        rsp_slverr_q  <= timed_out || bus.pslverr;
        rsp_timeout_q <= timed_out;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  apb_slave_decoder #(.NO_OF_SLAVES(NO_OF_SLAVES)) u_decoder (
    .slave_idx (cmd_q.addr[ADDRESS_WIDTH-1 -: SEL_W]),
    .sel_en    (sel_en),
    .pselx     (bus.pselx)
  );

  assign bus.penable     = penable_c;
  assign bus.paddr       = cmd_q.addr[ADDRESS_WIDTH-1:0];
  assign bus.pwrite      = (cmd_q.write == WRITE);
  assign bus.pwdata      = cmd_q.wdata[DATA_WIDTH-1:0];
  assign bus.pstrb       = cmd_q.strb[STRB_W-1:0];
  assign bus.pprot       = cmd_q.prot;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } rsp_t;

  logic pclk = 1'b0;
  logic preset;
  int   passed = 0;
  int   total  = 0;
  rsp_t sb[$];

  apb_master_bridge_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NO_OF_SLAVES(16)) bus ();

  apb_master_bridge #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NO_OF_SLAVES(16), .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus.master)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
  endtask

  task automatic check_rsp();
    rsp_t e;
    chk("rsp_valid", 32'(bus.rsp_valid), 1);
    chk("sb_depth", 32'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_rdata", bus.rsp_rdata, e.rdata);
      chk("rsp_slverr", 32'(bus.rsp_slverr), 32'(e.slverr));
      chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.timeout));
    end
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("drained", 32'(bus.rsp_valid), 0);
  endtask

  // Full transfer up to the response; waits = pready-low ACCESS cycles
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic [31:0] rdata, input logic err, input logic [15:0] sel);
    rsp_t e;
    e.rdata = wr ? 32'h0 : rdata;
    e.slverr = err;
    e.timeout = 1'b0;
    issue(wr, addr, wdata, strb, prot);
    sb.push_back(e);
    #1;
    chk("cmd_ready", 32'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("setup_pselx", 32'(bus.pselx), 32'(sel));
    chk("setup_penable", 32'(bus.penable), 0);
    chk("paddr", bus.paddr, addr);
    chk("pwrite", 32'(bus.pwrite), 32'(wr));
    chk("pwdata", bus.pwdata, wr ? wdata : 32'h0);
    chk("pstrb", 32'(bus.pstrb), wr ? 32'(strb) : 32'h0);
    chk("pprot", 32'(bus.pprot), 32'(prot));
    tick();
    for (int i = 0; i <= waits; i++) begin
      chk("access_penable", 32'(bus.penable), 1);
      chk("access_pselx", 32'(bus.pselx), 32'(sel));
      chk("access_paddr", bus.paddr, addr);
      chk("access_rsp_valid", 32'(bus.rsp_valid), 0);
      if (i == waits) begin
        bus.pready  = 1'b1;
        bus.prdata  = rdata;
        bus.pslverr = err;
      end
      tick();
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = 32'hBAD0_BAD0;
    chk("done_pselx", 32'(bus.pselx), 0);
    chk("done_penable", 32'(bus.penable), 0);
    check_rsp();
  endtask

  initial begin
    rsp_t e;
    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_pselx", 32'(bus.pselx), 0);
    chk("rst_penable", 32'(bus.penable), 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 0);
    preset = 1'b0;
    tick();
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);

    run_xfer(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 32'h0, 1'b0, 16'h0002);
    drain();
    run_xfer(1'b0, 32'hF000_0000, 32'hFFFF_FFFF, 4'hF, 3'b000, 2, 32'h1234_5678, 1'b0, 16'h8000);
    drain();
    run_xfer(1'b0, 32'h3000_0010, 32'h0, 4'h0, 3'b001, 1, 32'hCAFE_0001, 1'b1, 16'h0008);
    drain();

    // Response back-pressure with the next command already waiting
    run_xfer(1'b0, 32'h5000_0000, 32'h0, 4'h0, 3'b000, 0, 32'h0000_A5A5, 1'b0, 16'h0020);
    issue(1'b1, 32'h7000_0008, 32'h0BAD_CAFE, 4'h3, 3'b100);
    e.rdata = 32'h0; e.slverr = 1'b0; e.timeout = 1'b0;
    sb.push_back(e);
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("bp_pselx", 32'(bus.pselx), 0);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("drain_cmd_ready", 32'(bus.cmd_ready), 1);
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("bp_drained", 32'(bus.rsp_valid), 0);
    chk("bp_setup_pselx", 32'(bus.pselx), 32'h0080);
    chk("bp_setup_penable", 32'(bus.penable), 0);
    chk("bp_pstrb", 32'(bus.pstrb), 32'h3);
    tick();
    chk("bp_access_penable", 32'(bus.penable), 1);
    bus.pready = 1'b1;
    tick();
    bus.pready = 1'b0;
    check_rsp();
    drain();

`ifdef APB_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h2000_0000, 32'h0, 4'h0, 3'b000);
    e.rdata = 32'h0; e.slverr = 1'b1; e.timeout = 1'b1;
    sb.push_back(e);
    bus.prdata = 32'h600D_F00D;
    tick();
    bus.cmd_valid = 1'b0;
    chk("to_setup_pselx", 32'(bus.pselx), 32'h0004);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_penable", 32'(bus.penable), 1);
      chk("to_rsp_valid", 32'(bus.rsp_valid), 0);
      tick();
    end
    chk("to_penable_end", 32'(bus.penable), 0);
    check_rsp();
    drain();
`else
    run_xfer(1'b0, 32'h2000_0000, 32'h0, 4'h0, 3'b000, 12, 32'h600D_F00D, 1'b0, 16'h0004);
    drain();
`endif

    // Reset during ACCESS drops the transfer
    issue(1'b1, 32'h9000_0000, 32'h1111_2222, 4'hF, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("pre_rst_penable", 32'(bus.penable), 1);
    preset = 1'b1;
    tick();
    chk("mid_rst_pselx", 32'(bus.pselx), 0);
    chk("mid_rst_penable", 32'(bus.penable), 0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_paddr", bus.paddr, 0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 0);
    preset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);

    run_xfer(1'b1, 32'h1000_0000, 32'h5555_AAAA, 4'h5, 3'b011, 1, 32'h0, 1'b0, 16'h0002);
    drain();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
